// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage with a decoupling prefetch queue.
// Fetches sequential words from instruction memory ahead of decode, buffers
// them as {insn, pc} pairs in a circular queue and presents the oldest to
// the IF/ID register. Supports decode stall (keep), bubble injection (nop)
// and two-level redirect (early ID / late EX; late wins).
// Optional build macro FETCH_QUEUE_PERF_EN adds performance counters.
//
// Handshakes: memory side -- a word is accepted (pushed) on a rising edge
// when iready_n=0, the queue has room (or pops in the same cycle) and no
// redirect is active; decode side -- the head is consumed (popped) on a
// rising edge when inst_valid=1, keep=0, nop=0 and no redirect is active.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0001_0000,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     keep,
    input  logic                     nop,
    input  logic                     branch_PC_early_contral,
    input  logic [31:0]              branch_PC_early,
    input  logic                     branch_PC_contral,
    input  logic [31:0]              branch_PC,
    input  logic                     iready_n,
    input  logic [31:0]              idata,
    output logic [31:0]              iaddr,
    output logic [31:0]              Instraction_pype,
    output logic                     inst_valid,
    output logic [31:0]              PC_pype0,
    output logic [31:0]              PCp4_pype0,
    output logic [4:0]               fornop_register1_pype,
    output logic [4:0]               fornop_register2_pype,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]              perf_fetched,
    output logic [31:0]              perf_flushed,
    output logic [31:0]              perf_stall_cycles
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] FULL_CNT = OW'(DEPTH);

    // Queue storage (no reset needed: only entries below occupancy are read as valid)
    logic [31:0] insn_mem_q [DEPTH];
    logic [31:0] pc_mem_q   [DEPTH];

    logic [31:0]   iaddr_q, iaddr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [OW-1:0] occ_q, occ_d;

    logic          empty;
    logic          full;
    logic          redirect;
    logic [31:0]   target;
    logic          push;
    logic          pop;
    logic [31:0]   head_insn;
    logic [31:0]   head_pc;

    // Head presentation, straight from storage
    always_comb begin
        head_insn        = insn_mem_q[rd_ptr_q];
        head_pc          = pc_mem_q[rd_ptr_q];
        empty            = (occ_q == '0);
        full             = (occ_q == FULL_CNT);
        inst_valid       = !empty && !nop;
        Instraction_pype = inst_valid ? head_insn : NOP_INSN;
        PC_pype0         = empty ? iaddr_q : head_pc;
        PCp4_pype0       = PC_pype0 + 32'd4;
        fornop_register1_pype = Instraction_pype[19:15];
        fornop_register2_pype = Instraction_pype[24:20];
        iaddr            = iaddr_q;
        occupancy        = occ_q;
    end

    // Redirect target selection and push/pop decisions; late redirect wins
    always_comb begin
        redirect = branch_PC_contral || branch_PC_early_contral;
        target   = branch_PC_contral ? branch_PC : branch_PC_early;
        pop      = inst_valid && !keep && !nop && !redirect;
        push     = !iready_n && (!full || pop) && !redirect;
    end

    // Next-state for fetch address, pointers and occupancy
    always_comb begin
        iaddr_d  = iaddr_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (redirect) begin
            // Flush: pointers only need to agree, so snap read to write
            iaddr_d  = {target[31:2], 2'b00};
            rd_ptr_d = wr_ptr_q;
            occ_d    = '0;
        end else begin
            if (push) begin
                iaddr_d  = iaddr_q + 32'd4;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            iaddr_q  <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            iaddr_q  <= iaddr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Write accepted word and its fetch address into the tail slot
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            insn_mem_q[wr_ptr_q] <= idata;
            pc_mem_q[wr_ptr_q]   <= iaddr_q;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;
    logic [31:0] perf_stall_q,   perf_stall_d;

    // Counter increments: pushes, flushed entries (+ dropped same-cycle word), stall cycles
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_flushed_d = perf_flushed_q;
        perf_stall_d   = perf_stall_q;
        if (push) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (redirect) begin
            perf_flushed_d = perf_flushed_q + 32'(occ_q) + {31'd0, !iready_n};
        end
        if (!inst_valid || keep) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched      = perf_fetched_q;
    assign perf_flushed      = perf_flushed_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed stimulus for fetch_queue, checked
// against a queue-based reference model of the fetch stage.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          OW       = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC = 32'h0001_0000;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    logic          clk;
    logic          rst;
    logic          keep;
    logic          nop;
    logic          branch_PC_early_contral;
    logic [31:0]   branch_PC_early;
    logic          branch_PC_contral;
    logic [31:0]   branch_PC;
    logic          iready_n;
    logic [31:0]   idata;
    logic [31:0]   iaddr;
    logic [31:0]   Instraction_pype;
    logic          inst_valid;
    logic [31:0]   PC_pype0;
    logic [31:0]   PCp4_pype0;
    logic [4:0]    fornop_register1_pype;
    logic [4:0]    fornop_register2_pype;
    logic [OW-1:0] occupancy;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_flushed;
    logic [31:0]   perf_stall_cycles;
`endif

    fetch_queue #(
        .RESET_PC(RESET_PC),
        .DEPTH(DEPTH),
        .NOP_INSN(NOP_INSN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .keep(keep),
        .nop(nop),
        .branch_PC_early_contral(branch_PC_early_contral),
        .branch_PC_early(branch_PC_early),
        .branch_PC_contral(branch_PC_contral),
        .branch_PC(branch_PC),
        .iready_n(iready_n),
        .idata(idata),
        .iaddr(iaddr),
        .Instraction_pype(Instraction_pype),
        .inst_valid(inst_valid),
        .PC_pype0(PC_pype0),
        .PCp4_pype0(PCp4_pype0),
        .fornop_register1_pype(fornop_register1_pype),
        .fornop_register2_pype(fornop_register2_pype),
        .occupancy(occupancy)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0]   insn;
        logic [31:0]   pc;
        logic [31:0]   iaddr;
        logic          valid;
        logic [OW-1:0] occ;
        logic [31:0]   fetched;
        logic [31:0]   flushed;
        logic [31:0]   stalls;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: in-flight entries and fetch address
    logic [31:0] mq_insn[$];
    logic [31:0] mq_pc[$];
    logic [31:0] m_iaddr;
    logic [31:0] m_fetched, m_flushed, m_stalls;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h00A0_0093;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle with a pending expectation, compare presented outputs
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_t'(exp_q.pop_front());
            chk("iaddr", iaddr, e.iaddr);
            chk("occupancy", 32'(occupancy), 32'(e.occ));
            chk("inst_valid", 32'(inst_valid), 32'(e.valid));
            chk("insn", Instraction_pype, e.insn);
            chk("pc", PC_pype0, e.pc);
            chk("pcp4", PCp4_pype0, e.pc + 32'd4);
            chk("rs1", 32'(fornop_register1_pype), 32'(e.insn[19:15]));
            chk("rs2", 32'(fornop_register2_pype), 32'(e.insn[24:20]));
`ifdef FETCH_QUEUE_PERF_EN
            chk("perf_fetched", perf_fetched, e.fetched);
            chk("perf_flushed", perf_flushed, e.flushed);
            chk("perf_stall", perf_stall_cycles, e.stalls);
`endif
        end
    end

    // ---------------- driver ----------------
    // Drives one cycle of inputs, records expected outputs, advances the model.
    task automatic cycle(input logic k, input logic n, input logic bl, input logic be,
                         input logic [31:0] bpc, input logic [31:0] bpce,
                         input logic irn, input logic r);
        exp_t  e;
        logic  red, pop_m, push_m;
        logic [31:0] tgt, word;
        word = irn ? $urandom : mem_word(m_iaddr);
        keep = k; nop = n;
        branch_PC_contral = bl; branch_PC = bpc;
        branch_PC_early_contral = be; branch_PC_early = bpce;
        iready_n = irn; idata = word; rst = r;
        if (r) begin
            mq_insn.delete(); mq_pc.delete();
            m_iaddr = RESET_PC;
            m_fetched = '0; m_flushed = '0; m_stalls = '0;
        end else begin
            e.iaddr   = m_iaddr;
            e.occ     = OW'(mq_pc.size());
            e.fetched = m_fetched;
            e.flushed = m_flushed;
            e.stalls  = m_stalls;
            if (mq_pc.size() == 0) begin
                e.valid = 1'b0; e.insn = NOP_INSN; e.pc = m_iaddr;
            end else if (n) begin
                e.valid = 1'b0; e.insn = NOP_INSN; e.pc = mq_pc[0];
            end else begin
                e.valid = 1'b1; e.insn = mq_insn[0]; e.pc = mq_pc[0];
            end
            exp_q.push_back(W'(e));
            red    = bl || be;
            tgt    = bl ? bpc : bpce;
            pop_m  = e.valid && !k && !red;
            push_m = !irn && (mq_pc.size() < DEPTH || pop_m) && !red;
            if (!e.valid || k) m_stalls = m_stalls + 32'd1;
            if (push_m) m_fetched = m_fetched + 32'd1;
            if (red) begin
                m_flushed = m_flushed + 32'(mq_pc.size()) + (irn ? 32'd0 : 32'd1);
                mq_insn.delete(); mq_pc.delete();
                m_iaddr = tgt & 32'hFFFF_FFFC;
            end else begin
                if (pop_m) begin
                    void'(mq_insn.pop_front());
                    void'(mq_pc.pop_front());
                end
                if (push_m) begin
                    mq_insn.push_back(word);
                    mq_pc.push_back(m_iaddr);
                    m_iaddr = m_iaddr + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic k, input logic n, input logic irn);
        cycle(k, n, 1'b0, 1'b0, 32'h0, 32'h0, irn, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        keep = 0; nop = 0; branch_PC_contral = 0; branch_PC_early_contral = 0;
        branch_PC = 0; branch_PC_early = 0; iready_n = 1; idata = 0; rst = 1;
        m_iaddr = RESET_PC; m_fetched = 0; m_flushed = 0; m_stalls = 0;
        @(posedge clk); #1;
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        // Reset release and steady fill
        repeat (5) run(0, 0, 0);
        // Stall with keep until full, then release
        repeat (6) run(1, 0, 0);
        repeat (6) run(0, 0, 0);
        // Single-cycle bubble
        run(0, 1, 0);
        repeat (3) run(0, 0, 0);
        // Queue three entries, then both redirects together
        cycle(0, 0, 1, 0, 32'h0001_0000, 0, 1, 0);
        repeat (3) run(1, 0, 0);
        cycle(1, 0, 1, 1, 32'h0001_0100, 32'h0001_0200, 0, 0);
        run(0, 0, 1);
        // Misaligned late target, then early-only redirect
        cycle(0, 0, 1, 0, 32'h0001_0102, 0, 0, 0);
        repeat (2) run(0, 0, 0);
        cycle(0, 0, 0, 1, 0, 32'h0001_0207, 0, 0);
        repeat (2) run(0, 0, 0);
        // Memory wait pattern
        run(0, 0, 1); run(0, 0, 0); run(0, 0, 1); run(0, 0, 1); run(0, 0, 0);
        repeat (4) run(0, 0, 1);
        // Reset during fill and during a redirect
        repeat (3) run(1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) run(0, 0, 0);
        cycle(0, 0, 1, 1, 32'h0001_0300, 32'h0001_0400, 0, 1);
        repeat (2) run(0, 0, 0);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 19) == 0),
                  32'h0001_0000 + $urandom_range(0, 511),
                  32'h0001_0000 + $urandom_range(0, 511),
                  ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 99) == 0));
        end
        run(0, 0, 1);
        repeat (2) @(posedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with a decoupling prefetch queue, sitting between instruction memory and the IF/ID register of the 5-stage core. It runs ahead of decode: it fetches sequential words while memory is ready and the queue has room, buffers them with their PC, and presents the oldest one to decode. It supports stall, bubble injection and two-level redirect (early ID-stage and late EX-stage branch), with the late redirect taking priority.

## Interface
- `RESET_PC`, 32'h0001_0000: first fetch address after reset.
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `NOP_INSN`, 32'h0000_0013: word presented to decode when no valid instruction is available or a bubble is requested.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `keep` in 1: decode stall; the head entry is held and not popped.
- `nop` in 1: bubble request; decode sees `NOP_INSN` and the head is not popped.
- `branch_PC_early_contral` in 1: early redirect request from ID.
- `branch_PC_early` in 32: early redirect target.
- `branch_PC_contral` in 1: late redirect request from EX.
- `branch_PC` in 32: late redirect target.
- `iready_n` in 1: active-low; `idata` is valid for the current `iaddr` this cycle.
- `idata` in 32: instruction word from memory.
- `iaddr` out 32: fetch address, registered.
- `Instraction_pype` out 32: instruction to IF/ID.
- `inst_valid` out 1: `Instraction_pype` is a real queued instruction.
- `PC_pype0` out 32: PC of the presented instruction.
- `PCp4_pype0` out 32: `PC_pype0` + 4.
- `fornop_register1_pype` out 5: `Instraction_pype[19:15]`.
- `fornop_register2_pype` out 5: `Instraction_pype[24:20]`.
- `occupancy` out clog2(DEPTH)+1: number of valid queue entries.

## Operation
- **Queue.** Circular buffer with `DEPTH` entries of {insn, pc}. Read and write pointers are clog2(DEPTH) bits and wrap naturally. The full/empty distinction comes from `occupancy`.
- **Push.** Occurs when `iready_n`=0, queue not full (or a pop happens the same cycle), and no redirect this cycle. The stored entry is {`idata`, `iaddr`}, and `iaddr` becomes `iaddr`+4.
- **Pop.** Occurs when `inst_valid`=1, `keep`=0, `nop`=0, and no redirect this cycle.
- **Push and pop in the same cycle.** Both are allowed, including when the queue is full; `occupancy` is unchanged.
- **Presentation.** The outputs come from the head entry, combinationally from storage.
  - If the queue is empty or `nop`=1: `Instraction_pype`=`NOP_INSN` and `inst_valid`=0, but `PC_pype0` still shows the head PC. When the queue is empty it shows `iaddr`.
  - `PCp4_pype0` is always `PC_pype0`+4, with a 32-bit wrap.
- **Redirect.**
  - Target selection: `branch_PC_contral`=1 uses `branch_PC`; otherwise `branch_PC_early_contral`=1 uses `branch_PC_early`. The late redirect wins when both are asserted.
  - On a redirect, the queue is flushed (`occupancy`←0), any `idata` returned that cycle is discarded, and `iaddr`←{target[31:2], 2'b00}.
  - A redirect overrides `keep` and `nop`.
- **Reset.** `iaddr`=`RESET_PC`, `occupancy`=0, pointers=0. Outputs are then `Instraction_pype`=`NOP_INSN`, `inst_valid`=0, `PC_pype0`=`RESET_PC`, `PCp4_pype0`=`RESET_PC`+4. A reset asserted mid-redirect or mid-fill wins over everything.

## Timing
- **Fetch to decode latency.** A word accepted in cycle N is visible at the head in cycle N+1 if the queue was empty.
- **Redirect latency.** A redirect in cycle N gives `iaddr`=target in cycle N+1. The first target instruction is at decode no earlier than N+2.
- **Throughput.** Sustained 1 instruction/cycle with `iready_n`=0 and no stalls.
- **Memory wait.** `iready_n`=1 holds `iaddr` and pushes nothing.
- **Full queue.** Holds `iaddr` and ignores `idata`; memory must re-present the word when fetch retries.

## Configuration
- Macro: `FETCH_QUEUE_PERF_EN`.
- **With the macro defined:** adds 32-bit outputs `perf_fetched`, `perf_flushed` and `perf_stall_cycles`. They count, respectively, pushes; entries discarded by redirects (the `occupancy` at the flush plus any discarded same-cycle `idata`); and cycles with `inst_valid`=0 or `keep`=1. All three clear on reset and wrap at 2^32.
- **Without the macro:** these ports and counters are absent. All other behaviour is identical.

## Test plan
- **Reset release.** Hold `iready_n`=0 and supply `idata`=0x00A00093, 0x00B00113, … → `iaddr` steps 0x10000, 0x10004, 0x10008; decode sees 0x00A00093 with `PC_pype0`=0x10000 one cycle after the first accept.
- **Stall with `keep`.** Hold `keep`=1 for 6 cycles with `DEPTH`=4 → `occupancy` saturates at 4 and `iaddr` freezes at 0x10010. Release → pops resume in order, with no lost or duplicated PCs.
- **Bubble with `nop`.** Pulse `nop`=1 for one cycle → `Instraction_pype`=0x00000013 and `inst_valid`=0. The next cycle shows the same head PC again.
- **Simultaneous redirects.** Assert both redirects with `branch_PC`=0x10100 and `branch_PC_early`=0x10200 while 3 entries are queued → next cycle `iaddr`=0x10100 and `occupancy`=0. A misaligned target 0x10102 gives `iaddr`=0x10100.
- **Memory wait.** Apply `iready_n`=1 pattern 1,0,1,1,0 → exactly two pushes, `iaddr` advances by 8 in total, and decode sees the correct PC/word pairs.
- **Reset during fill, perf build.** Assert `rst` mid-fill with `FETCH_QUEUE_PERF_EN` defined → next cycle `iaddr`=0x10000, `occupancy`=0, and all perf counters are 0.
